// File: rtl/res_mem_arbiter.sv
// rtl/res_mem_arbiter.sv - two-port arbiter for the single-port result memory
// Port 0 has fixed priority; a starvation counter forces a port-1 slot after STARVE_LIMIT port-0 wins.
module res_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di,
  output logic              busy
);

  localparam logic [7:0] LIMIT = STARVE_LIMIT[7:0];

  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } pri_e;

  pri_e              state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              res_rd_q, res_rd_d;
  logic              res_wr_q, res_wr_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_do_q, res_do_d;
  logic              owner_q, owner_d;
  logic              rv_q, rv_d;
  logic              rv_owner_q, rv_owner_d;

  logic gnt0, gnt1, acc0, acc1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (state_q == PRI_M0) begin
        gnt0 = m0_req;
        gnt1 = m1_req && !m0_req && !m0_lock;
      end else begin
        gnt1 = m1_req && !m0_lock;
        gnt0 = m0_req && !gnt1;
      end
    end
  end

  assign acc0 = m0_req && gnt0;
  assign acc1 = m1_req && gnt1;

  // The lock freezes the counter so port 1 still owes its slot when lock drops.
  always_comb begin
    cnt_d = cnt_q;
    if (!m0_lock) begin
      if (!m1_req || acc1) begin
        cnt_d = 8'd0;
      end else if (acc0 && cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRI_M0: if (acc0 && !m0_lock && m1_req && cnt_d == LIMIT) state_d = PRI_M1;
      PRI_M1: if (acc1 || !m1_req) state_d = PRI_M0;
      default: state_d = PRI_M0;
    endcase
  end

  always_comb begin
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_do_d   = res_do_q;
    owner_d    = owner_q;
    if (acc1) begin
      res_rd_d   = !m1_wr;
      res_wr_d   = m1_wr;
      res_addr_d = m1_addr;
      if (m1_wr) res_do_d = m1_wdata;
      owner_d    = 1'b1;
    end else if (acc0) begin
      res_rd_d   = !m0_wr;
      res_wr_d   = m0_wr;
      res_addr_d = m0_addr;
      if (m0_wr) res_do_d = m0_wdata;
      owner_d    = 1'b0;
    end
    rv_d       = res_rd_q;
    rv_owner_d = owner_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PRI_M0;
      cnt_q      <= 8'd0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
      owner_q    <= 1'b0;
      rv_q       <= 1'b0;
      rv_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_rd_q   <= res_rd_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_do_q   <= res_do_d;
      owner_q    <= owner_d;
      rv_q       <= rv_d;
      rv_owner_q <= rv_owner_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign res_rd    = res_rd_q;
  assign res_wr    = res_wr_q;
  assign res_addr  = res_addr_q;
  assign res_do    = res_do_q;
  assign busy      = res_rd_q | res_wr_q;
  assign m0_rvalid = rv_q && !rv_owner_q;
  assign m1_rvalid = rv_q && rv_owner_q;
  assign m0_rdata  = res_di;
  assign m1_rdata  = res_di;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// tb/tb_res_mem_arbiter.sv - directed self-checking bench for res_mem_arbiter
module tb_res_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wr, m0_lock, m0_gnt, m0_rvalid;
    logic [13:0] m0_addr;
    logic [7:0]  m0_wdata, m0_rdata;
    logic        m1_req, m1_wr, m1_gnt, m1_rvalid;
    logic [13:0] m1_addr;
    logic [7:0]  m1_wdata, m1_rdata;
    logic        res_rd, res_wr, busy;
    logic [13:0] res_addr;
    logic [7:0]  res_do, res_di;

    int checks = 0;
    int errors = 0;

    res_mem_arbiter #(.STARVE_LIMIT(8), .ADDR_W(14), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
        .res_di(res_di), .busy(busy)
    );

    task automatic chk(input string tag, input logic ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    function automatic logic [7:0] pat(input logic [13:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    logic [7:0] mem [0:16383];
    bit mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 16384; k++) mem[k] = pat(14'(k));
            mem_init = 1'b1;
        end
        if (res_rd) res_di <= mem[res_addr];
        if (res_wr) mem[res_addr] = res_do;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic        exp_p [0:31];
    logic [7:0]  exp_d [0:31];
    logic [13:0] a0, a1;
    logic        w;

    initial begin
        reset = 1'b0; m0_lock = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        chk("rst_m0_gnt", m0_gnt === 1'b0);
        chk("rst_m1_gnt", m1_gnt === 1'b0);
        chk("rst_res_rd", res_rd === 1'b0);
        chk("rst_res_wr", res_wr === 1'b0);
        chk("rst_res_addr", res_addr === 14'd0);
        chk("rst_res_do", res_do === 8'd0);
        chk("rst_busy", busy === 1'b0);
        chk("rst_m0_rvalid", m0_rvalid === 1'b0);
        chk("rst_m1_rvalid", m1_rvalid === 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;

        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 14'd130; m0_wdata = 8'd5;
        #1 chk("t1_wr_gnt", m0_gnt === 1'b1);
        @(posedge clk); #1;
        chk("t1_res_wr", res_wr === 1'b1);
        chk("t1_res_rd0", res_rd === 1'b0);
        chk("t1_addr_w", res_addr === 14'd130);
        chk("t1_res_do", res_do === 8'd5);
        chk("t1_busy", busy === 1'b1);
        m0_wr = 1'b0;
        #1 chk("t1_rd_gnt", m0_gnt === 1'b1);
        @(posedge clk); #1;
        chk("t1_res_rd", res_rd === 1'b1);
        chk("t1_res_wr0", res_wr === 1'b0);
        chk("t1_addr_r", res_addr === 14'd130);
        chk("t1_no_rv_wr", m0_rvalid === 1'b0);
        m0_req = 1'b0;
        @(posedge clk); #1;
        chk("t1_m0_rvalid", m0_rvalid === 1'b1);
        chk("t1_m0_rdata", m0_rdata === 8'd5);
        chk("t1_m1_rvalid", m1_rvalid === 1'b0);
        chk("t1_busy_idle", busy === 1'b0);

        a0 = 14'd200; a1 = 14'd1000;
        m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
        for (int i = 0; i < 18; i++) begin
            m0_addr = a0; m1_addr = a1;
            w = ((i % 9) == 8);
            #1;
            chk("t2_m0_gnt", m0_gnt === !w);
            chk("t2_m1_gnt", m1_gnt === w);
            exp_p[i] = w;
            exp_d[i] = w ? pat(a1) : pat(a0);
            @(posedge clk); #1;
            if (w) a1 = a1 + 14'd1; else a0 = a0 + 14'd1;
            if (i > 0) begin
                chk("t2_m0_rvalid", m0_rvalid === !exp_p[i-1]);
                chk("t2_m1_rvalid", m1_rvalid === exp_p[i-1]);
                chk("t2_rdata", (exp_p[i-1] ? m1_rdata : m0_rdata) === exp_d[i-1]);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        chk("t2_last_m1_rvalid", m1_rvalid === 1'b1);
        chk("t2_last_rdata", m1_rdata === exp_d[17]);

        m0_addr = 14'd300; m1_addr = 14'd2000;
        m0_req = 1'b1; m1_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t3_state_pri1", dut.state_q === 1'b1);
        chk("t3_cnt_limit", dut.cnt_q === 8'd8);
        m0_lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t3_lock_m1_gnt", m1_gnt === 1'b0);
            chk("t3_lock_m0_gnt", m0_gnt === 1'b1);
            @(posedge clk); #1;
            chk("t3_cnt_frozen", dut.cnt_q === 8'd8);
        end
        m0_lock = 1'b0;
        #1;
        chk("t3_unlock_m1_gnt", m1_gnt === 1'b1);
        chk("t3_unlock_m0_gnt", m0_gnt === 1'b0);
        @(posedge clk); #1;
        chk("t3_m1_addr", res_addr === 14'd2000);
        chk("t3_state_back", dut.state_q === 1'b0);
        chk("t3_cnt_clr", dut.cnt_q === 8'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 14'd16383;
        #1;
        chk("t4_m1_gnt_a", m1_gnt === 1'b1);
        chk("t4_m0_gnt", m0_gnt === 1'b0);
        @(posedge clk); #1;
        m1_addr = 14'd0;
        #1 chk("t4_m1_gnt_b", m1_gnt === 1'b1);
        @(posedge clk); #1;
        m1_req = 1'b0;
        chk("t4_rv_a", m1_rvalid === 1'b1);
        chk("t4_rdata_a", m1_rdata === 8'hA5);
        chk("t4_m0_rv_a", m0_rvalid === 1'b0);
        @(posedge clk); #1;
        chk("t4_rv_b", m1_rvalid === 1'b1);
        chk("t4_rdata_b", m1_rdata === 8'h5A);
        chk("t4_m0_rv_b", m0_rvalid === 1'b0);
        @(posedge clk); #1;
        chk("t4_rv_end", m1_rvalid === 1'b0);

        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 14'd77;
        @(posedge clk); #1;
        chk("t5_pre_rd", res_rd === 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_res_rd", res_rd === 1'b0);
        chk("t5_res_addr", res_addr === 14'd0);
        chk("t5_busy", busy === 1'b0);
        chk("t5_m0_gnt", m0_gnt === 1'b0);
        chk("t5_m0_rvalid", m0_rvalid === 1'b0);
        m0_req = 1'b0;
        @(posedge clk); #1;
        chk("t5_in_rst_rv", m0_rvalid === 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_post_rv0", m0_rvalid === 1'b0);
        @(posedge clk); #1;
        chk("t5_post_rv1", m0_rvalid === 1'b0);
        chk("t5_post_m1rv", m1_rvalid === 1'b0);
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 14'd9;
        #1;
        chk("t5_first_m0_gnt", m0_gnt === 1'b1);
        chk("t5_first_m1_gnt", m1_gnt === 1'b0);
        @(posedge clk); #1;
        chk("t5_first_addr", res_addr === 14'd77);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        chk("t5_first_rv", m0_rvalid === 1'b1);
        chk("t5_first_rdata", m0_rdata === pat(14'd77));

        m0_addr = 14'd500; m1_addr = 14'd3000;
        m0_req = 1'b1; m1_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_state_pri1", dut.state_q === 1'b1);
        chk("t6_cnt_limit", dut.cnt_q === 8'd8);
        m1_req = 1'b0;
        #1 chk("t6_m0_gnt", m0_gnt === 1'b1);
        @(posedge clk); #1;
        chk("t6_state_m0", dut.state_q === 1'b0);
        chk("t6_cnt_clr", dut.cnt_q === 8'd0);
        m0_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
